// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM state type and limits; PARITY state exists only with UART_PARITY_EN
package uart_pkg;

    localparam int MIN_DIV       = 16;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP  = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable down-counter; tick flags the final cycle of a loaded interval
module uart_baud_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Loading N yields a tick N cycles later, so reloading on tick gives exact N-cycle bits.
    assign tick_o = (cnt_q == W'(1));

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART transmitter and receiver with independent FSMs; parity bit added with UART_PARITY_EN
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int DIV_RAW = CLK_FREQ / BAUD;
    localparam int DIV     = (DIV_RAW < MIN_DIV) ? MIN_DIV : DIV_RAW;
    localparam int CW      = $clog2(DIV + 1);
    localparam int BW      = $clog2(DATA_BITS_MAX + 1);
    localparam logic [CW-1:0] DIV_FULL  = CW'(DIV);
    localparam logic [CW-1:0] DIV_HALF  = CW'(DIV / 2);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_ready_q, tx_load, tx_tick;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    uart_baud_cnt #(.W(CW)) u_tx_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (DIV_FULL),
        .tick_o     (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            ST_IDLE: if (tx_valid && tx_ready_q) begin
                tx_state_d = ST_START;
                tx_shift_d = tx_data;
                tx_load    = 1'b1;
`ifdef UART_PARITY_EN
                tx_par_d   = (^tx_data) ^ PARITY_ODD;
`endif
            end
            ST_START: if (tx_tick) begin
                tx_state_d = ST_DATA;
                tx_bit_d   = '0;
                tx_load    = 1'b1;
            end
            ST_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_load    = 1'b1;
                if (tx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                    tx_state_d = ST_PARITY;
`else
                    tx_state_d = ST_STOP;
                    tx_bit_d   = '0;
`endif
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (tx_tick) begin
                tx_state_d = ST_STOP;
                tx_bit_d   = '0;
                tx_load    = 1'b1;
            end
`endif
            ST_STOP: if (tx_tick) begin
                if (tx_bit_q == LAST_STOP) begin
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                    tx_load  = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Line level is registered from next state so uart_tx never glitches.
        case (tx_state_d)
            ST_START:  tx_line_d = 1'b0;
            ST_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_line_d = tx_par_d;
`endif
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= (tx_state_d == ST_IDLE);
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx_ready = tx_ready_q;
    assign uart_tx  = tx_line_q;

    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
    logic                 rx_load, rx_tick;
    logic [CW-1:0]        rx_load_val;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad_q, rx_par_bad_d, rx_perr_q, rx_perr_d;
`endif

    uart_baud_cnt #(.W(CW)) u_rx_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .tick_o     (rx_tick)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_bit_d    = rx_bit_q;
        rx_valid_d  = 1'b0;
        rx_ferr_d   = rx_ferr_q;
        rx_load     = 1'b0;
        rx_load_val = DIV_FULL;
`ifdef UART_PARITY_EN
        rx_par_bad_d = rx_par_bad_q;
        rx_perr_d    = rx_perr_q;
`endif
        case (rx_state_q)
            // Only a falling edge arms RX, so a held-low break line cannot retrigger.
            ST_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d  = ST_START;
                rx_load     = 1'b1;
                rx_load_val = DIV_HALF;
            end
            ST_START: if (rx_tick) begin
                if (!rx_s2_q) begin
                    rx_state_d = ST_DATA;
                    rx_bit_d   = '0;
                    rx_load    = 1'b1;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                rx_load    = 1'b1;
                if (rx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                    rx_state_d = ST_PARITY;
`else
                    rx_state_d = ST_STOP;
`endif
                end else begin
                    rx_bit_d = rx_bit_q + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (rx_tick) begin
                rx_par_bad_d = rx_s2_q ^ (^rx_shift_q) ^ PARITY_ODD;
                rx_state_d   = ST_STOP;
                rx_load      = 1'b1;
            end
`endif
            ST_STOP: if (rx_tick) begin
                rx_state_d = ST_IDLE;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = !rx_s2_q;
`ifdef UART_PARITY_EN
                rx_perr_d  = rx_par_bad_q;
`endif
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_bit_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= rx_par_bad_d;
            rx_perr_q    <= rx_perr_d;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core; parity steps run when UART_PARITY_EN is defined
module tb_uart_core;

    localparam int CLK_FREQ  = 2000000;
    localparam int BAUD      = 100000;
    localparam int DIV       = CLK_FREQ / BAUD;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DATA_BITS + PB + STOP_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err;
    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;

    bit         fb[$];
    logic [9:0] got[$];

    always #5 clk = ~clk;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) got.push_back({rx_data, rx_frame_err, rx_parity_err});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity making the ones-count even, stop bits.
    task automatic build_frame(input logic [7:0] d, input bit par_flip, input bit stop_val);
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) fb.push_back(d[i]);
`ifdef UART_PARITY_EN
        fb.push_back(bit'(($countones(d) % 2) == 1) ^ par_flip);
`endif
        for (int i = 0; i < STOP_BITS; i++) fb.push_back(stop_val);
    endtask

    task automatic drive_frame();
        for (int i = 0; i < fb.size(); i++) begin
            rx_drv = fb[i];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 4 * NB * DIV) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] d);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic tx_frame_test(input logic [7:0] d);
        int bad_at = -1;
        build_frame(d, 1'b0, 1'b1);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        for (int c = 0; c < NB * DIV; c++) begin
            @(negedge clk);
            if (uart_tx !== fb[c / DIV] && bad_at < 0) bad_at = c;
            if (c == 0) check("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
            if (c == NB * DIV - 1) begin
                check("tx_ready_last_stop", {31'd0, tx_ready}, 32'd0);
                tx_valid = 1'b0;
            end
            tx_data = 8'($urandom_range(0, 255));
        end
        check("tx_wave_first_bad_cycle", bad_at, -1);
        @(negedge clk);
        check("tx_ready_return", {31'd0, tx_ready}, 32'd1);
        check("tx_idle_high", {31'd0, uart_tx}, 32'd1);
    endtask

    initial begin
        logic [7:0] words[$];
        logic [7:0] w;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_errs", {30'd0, rx_frame_err, rx_parity_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tx_ready_after_rst", {31'd0, tx_ready}, 32'd1);

        tx_frame_test(8'hB6);
        for (int k = 0; k < 2; k++) tx_frame_test(8'($urandom_range(0, 255)));

        loop_en = 1'b1;
        got.delete();
        words = '{8'hB6, 8'hE7, 8'hF0, 8'h02};
        for (int k = 0; k < 3; k++) words.push_back(8'($urandom_range(0, 255)));
        foreach (words[i]) send_word(words[i]);
        wait_ready();
        repeat (2 * DIV) @(negedge clk);
        check("loop_count", got.size(), words.size());
        foreach (words[i]) begin
            if (i < got.size()) begin
                check("loop_data", {24'd0, got[i][9:2]}, {24'd0, words[i]});
                check("loop_errs", {30'd0, got[i][1:0]}, 32'd0);
            end
        end
        loop_en = 1'b0;

        got.delete();
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_no_strobe", got.size(), 0);
        w = 8'($urandom_range(0, 255));
        build_frame(w, 1'b0, 1'b1);
        drive_frame();
        repeat (DIV) @(negedge clk);
        check("post_glitch_count", got.size(), 1);
        if (got.size() > 0) check("post_glitch_data", {22'd0, got[0]}, {22'd0, w, 2'b00});

        got.delete();
        build_frame(8'h55, 1'b0, 1'b0);
        drive_frame();
        rx_drv = 1'b0;
        repeat (3 * NB * DIV) @(negedge clk);
        check("break_count", got.size(), 1);
        if (got.size() > 0) check("break_rec", {22'd0, got[0]}, {22'd0, 8'h55, 2'b10});
        rx_drv = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("break_no_more", got.size(), 1);
        w = 8'($urandom_range(0, 255));
        build_frame(w, 1'b0, 1'b1);
        drive_frame();
        repeat (DIV) @(negedge clk);
        check("rearm_count", got.size(), 2);
        if (got.size() > 1) check("rearm_rec", {22'd0, got[1]}, {22'd0, w, 2'b00});

`ifdef UART_PARITY_EN
        got.delete();
        build_frame(8'h07, 1'b1, 1'b1);
        drive_frame();
        repeat (DIV) @(negedge clk);
        build_frame(8'h07, 1'b0, 1'b1);
        drive_frame();
        repeat (DIV) @(negedge clk);
        check("par_count", got.size(), 2);
        if (got.size() > 1) begin
            check("par_bad", {22'd0, got[0]}, {22'd0, 8'h07, 2'b01});
            check("par_good", {22'd0, got[1]}, {22'd0, 8'h07, 2'b00});
        end
`endif

        got.delete();
        build_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        tx_data  = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        for (int c = 0; c < 4 * DIV + 7; c++) begin
            rx_drv = fb[c / DIV];
            @(negedge clk);
            tx_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst    = 1'b0;
        rx_drv = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", {31'd0, tx_ready}, 32'd1);
        repeat (2 * NB * DIV) @(negedge clk);
        check("midrst_no_strobe", got.size(), 0);
        check("midrst_tx_idle", {31'd0, uart_tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
